// File: rtl/logic_gates_checker_pkg.sv
// Shared types and golden-value helper for the two-input gate checker.
// Gate bit order (LSB first): nand, inv, and, or, xor.
package logic_gates_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int NUM_GATES   = 5;

    localparam int ERR_NAND = 0;
    localparam int ERR_INV  = 1;
    localparam int ERR_AND  = 2;
    localparam int ERR_OR   = 3;
    localparam int ERR_XOR  = 4;

    function automatic logic [NUM_GATES-1:0] gate_expected(input logic a, input logic b);
        logic [NUM_GATES-1:0] g;
        g           = '0;
        g[ERR_NAND] = ~(a & b);
        g[ERR_INV]  = ~a;
        g[ERR_AND]  = a & b;
        g[ERR_OR]   = a | b;
        g[ERR_XOR]  = a ^ b;
        return g;
    endfunction

endpackage

// File: rtl/logic_gates_checker_if.sv
// Bundle between the checker and the gate block under test, plus run control/status.
// The slave modport is the checker; the master modport is whoever drives start and the gate results.
interface logic_gates_checker_if;

    logic                                   start;
    logic                                   a_out;
    logic                                   b_out;
    logic                                   out_nand_in;
    logic                                   out_inv_in;
    logic                                   out_and_in;
    logic                                   out_or_in;
    logic                                   out_xor_in;
    logic                                   busy;
    logic                                   done;
    logic                                   pass;
    logic [logic_gates_pkg::NUM_VECTORS-1:0] fail_vec;
    logic [logic_gates_pkg::NUM_GATES-1:0]   err_mask;
    logic [2:0]                             fail_count;

    modport slave (
        input  start,
        input  out_nand_in, out_inv_in, out_and_in, out_or_in, out_xor_in,
        output a_out, b_out,
        output busy, done, pass, fail_vec, err_mask, fail_count
    );

    modport master (
        output start,
        output out_nand_in, out_inv_in, out_and_in, out_or_in, out_xor_in,
        input  a_out, b_out,
        input  busy, done, pass, fail_vec, err_mask, fail_count
    );

endinterface

// File: rtl/logic_gates_checker_compare.sv
// Combinational per-gate mismatch detector: one bit per gate, set where the
// observed result differs from the golden value for operands a/b.
module gate_compare
    import logic_gates_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    input  logic                 out_nand,
    input  logic                 out_inv,
    input  logic                 out_and,
    input  logic                 out_or,
    input  logic                 out_xor,
    output logic [NUM_GATES-1:0] mismatch
);

    logic [NUM_GATES-1:0] observed;

    always_comb begin
        observed           = '0;
        observed[ERR_NAND] = out_nand;
        observed[ERR_INV]  = out_inv;
        observed[ERR_AND]  = out_and;
        observed[ERR_OR]   = out_or;
        observed[ERR_XOR]  = out_xor;
        mismatch           = observed ^ gate_expected(a, b);
    end

endmodule

// File: rtl/logic_gates_checker.sv
// BIST engine for the two-input gate block: walks {a,b} through 00..11, waits
// SETTLE_CYCLES per vector, samples the five gate results and accumulates errors.
module logic_gates_checker
    import logic_gates_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    logic_gates_checker_if.slave  bus
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   a_q, a_d;
    logic                   b_q, b_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_VECTORS-1:0] fail_vec_q, fail_vec_d;
    logic [NUM_GATES-1:0]   err_mask_q, err_mask_d;
    logic [2:0]             fail_count_q, fail_count_d;
    logic [NUM_GATES-1:0]   mismatch;

    gate_compare u_compare (
        .a        (a_q),
        .b        (b_q),
        .out_nand (bus.out_nand_in),
        .out_inv  (bus.out_inv_in),
        .out_and  (bus.out_and_in),
        .out_or   (bus.out_or_in),
        .out_xor  (bus.out_xor_in),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_vec_q   <= '0;
            err_mask_q   <= '0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_vec_q   <= fail_vec_d;
            err_mask_q   <= err_mask_d;
            fail_count_q <= fail_count_d;
        end
    end

    // start is only honoured when no run is in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = DRIVE;
            DRIVE:      state_d = SETTLE;
            SETTLE:     if (cnt_q == CNT_W'(1)) state_d = SAMPLE;
            SAMPLE:     state_d = (idx_q == 2'(NUM_VECTORS - 1)) ? DONE : DRIVE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        fail_vec_d = fail_vec_q;
        err_mask_d = err_mask_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    idx_d      = '0;
                    {a_d, b_d} = 2'b00;
                    fail_vec_d = '0;
                    err_mask_d = '0;
                end
            end
            DRIVE:  cnt_d = CNT_W'(SETTLE_CYCLES);
            SETTLE: cnt_d = cnt_q - CNT_W'(1);
            SAMPLE: begin
                if (|mismatch) begin
                    fail_vec_d[idx_q] = 1'b1;
                    err_mask_d        = err_mask_q | mismatch;
                end
                // the next operand pair is launched on the same edge that enters DRIVE
                if (idx_q != 2'(NUM_VECTORS - 1)) begin
                    idx_d      = idx_q + 2'd1;
                    {a_d, b_d} = idx_q + 2'd1;
                end
            end
            default: ;
        endcase
        busy_d       = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == SAMPLE);
        done_d       = (state_d == DONE);
        fail_count_d = 3'($countones(fail_vec_d));
    end

    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = done_q && (fail_vec_q == '0);
    assign bus.fail_vec   = fail_vec_q;
    assign bus.err_mask   = err_mask_q;
    assign bus.fail_count = fail_count_q;

endmodule
